// File: rtl/id_defs_pkg.sv
// Shared decode constants for the id stage: opcodes, functs,
// ALU operation codes and immediate-extension selection.
package id_defs_pkg;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_ADDI    = 6'h08;
  localparam logic [5:0] OP_ADDIU   = 6'h09;
  localparam logic [5:0] OP_SLTI    = 6'h0A;
  localparam logic [5:0] OP_SLTIU   = 6'h0B;
  localparam logic [5:0] OP_ANDI    = 6'h0C;
  localparam logic [5:0] OP_ORI     = 6'h0D;
  localparam logic [5:0] OP_XORI    = 6'h0E;
  localparam logic [5:0] OP_LUI     = 6'h0F;
  localparam logic [5:0] OP_PREF    = 6'h33;

  localparam logic [5:0] F_SLL  = 6'h00;
  localparam logic [5:0] F_SRL  = 6'h02;
  localparam logic [5:0] F_SRA  = 6'h03;
  localparam logic [5:0] F_SLLV = 6'h04;
  localparam logic [5:0] F_SRLV = 6'h06;
  localparam logic [5:0] F_SRAV = 6'h07;
  localparam logic [5:0] F_SYNC = 6'h0F;
  localparam logic [5:0] F_ADD  = 6'h20;
  localparam logic [5:0] F_ADDU = 6'h21;
  localparam logic [5:0] F_SUB  = 6'h22;
  localparam logic [5:0] F_SUBU = 6'h23;
  localparam logic [5:0] F_AND  = 6'h24;
  localparam logic [5:0] F_OR   = 6'h25;
  localparam logic [5:0] F_XOR  = 6'h26;
  localparam logic [5:0] F_NOR  = 6'h27;
  localparam logic [5:0] F_SLT  = 6'h2A;
  localparam logic [5:0] F_SLTU = 6'h2B;

  localparam logic [7:0] ALU_NOP  = 8'h00;
  localparam logic [7:0] ALU_SRL  = 8'h02;
  localparam logic [7:0] ALU_SRA  = 8'h03;
  localparam logic [7:0] ALU_ADD  = 8'h20;
  localparam logic [7:0] ALU_ADDU = 8'h21;
  localparam logic [7:0] ALU_AND  = 8'h24;
  localparam logic [7:0] ALU_OR   = 8'h25;
  localparam logic [7:0] ALU_XOR  = 8'h26;
  localparam logic [7:0] ALU_SLT  = 8'h2A;
  localparam logic [7:0] ALU_SLTU = 8'h2B;
  localparam logic [7:0] ALU_SLL  = 8'h7C;

  typedef enum logic [2:0] {
    IMM_NONE,
    IMM_ZERO,
    IMM_SIGN,
    IMM_LUI,
    IMM_SHAMT
  } imm_ext_e;

  function automatic logic [31:0] ext_imm(
    input imm_ext_e   e,
    input logic [31:0] inst
  );
    logic [31:0] r;
    r = 32'h0;
    case (e)
      IMM_ZERO:  r = {16'h0, inst[15:0]};
      IMM_SIGN:  r = {{16{inst[15]}}, inst[15:0]};
      IMM_LUI:   r = {inst[15:0], 16'h0};
      IMM_SHAMT: r = {27'h0, inst[10:6]};
      default:   r = 32'h0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/id_decode.sv
// Combinational MIPS instruction decode: ALU op, read enables,
// destination, per-operand immediates and invalid flag.
module id_decode
  import id_defs_pkg::*;
(
  input  logic [31:0] inst,
  output logic [7:0]  aluop,
  output logic        re1,
  output logic        re2,
  output logic [4:0]  wd,
  output logic        wreg,
  output logic [31:0] imm1,
  output logic [31:0] imm2,
  output logic        inv
);

  logic [5:0] op;
  logic [5:0] funct;
  logic [4:0] rt;
  logic [4:0] rd;
  imm_ext_e   e1;
  imm_ext_e   e2;

  assign op    = inst[31:26];
  assign funct = inst[5:0];
  assign rt    = inst[20:16];
  assign rd    = inst[15:11];

  always_comb begin
    aluop = ALU_NOP;
    re1   = 1'b0;
    re2   = 1'b0;
    wd    = 5'd0;
    wreg  = 1'b0;
    inv   = 1'b0;
    e1    = IMM_NONE;
    e2    = IMM_NONE;
    unique case (op)
      OP_SPECIAL: begin
        unique case (funct)
          F_AND, F_OR, F_XOR, F_NOR,
          F_ADD, F_ADDU, F_SUB, F_SUBU,
          F_SLT, F_SLTU: begin
            aluop = {2'b00, funct};
            re1   = 1'b1;
            re2   = 1'b1;
            wd    = rd;
            wreg  = 1'b1;
          end
          F_SLLV, F_SRLV, F_SRAV: begin
            aluop = (funct == F_SLLV) ? ALU_SLL :
                    (funct == F_SRLV) ? ALU_SRL : ALU_SRA;
            re1   = 1'b1;
            re2   = 1'b1;
            wd    = rd;
            wreg  = 1'b1;
          end
          // constant shifts take shamt in place of rs
          F_SLL, F_SRL, F_SRA: begin
            aluop = (funct == F_SLL) ? ALU_SLL :
                    (funct == F_SRL) ? ALU_SRL : ALU_SRA;
            re2   = 1'b1;
            e1    = IMM_SHAMT;
            wd    = rd;
            wreg  = 1'b1;
          end
          F_SYNC: aluop = ALU_SLL;
          default: inv = 1'b1;
        endcase
      end
      OP_ANDI, OP_ORI, OP_XORI: begin
        aluop = (op == OP_ANDI) ? ALU_AND :
                (op == OP_ORI)  ? ALU_OR  : ALU_XOR;
        re1   = 1'b1;
        e2    = IMM_ZERO;
        wd    = rt;
        wreg  = 1'b1;
      end
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU: begin
        aluop = (op == OP_ADDI)  ? ALU_ADD  :
                (op == OP_ADDIU) ? ALU_ADDU :
                (op == OP_SLTI)  ? ALU_SLT  : ALU_SLTU;
        re1   = 1'b1;
        e2    = IMM_SIGN;
        wd    = rt;
        wreg  = 1'b1;
      end
      OP_LUI: begin
        aluop = ALU_OR;
        e2    = IMM_LUI;
        wd    = rt;
        wreg  = 1'b1;
      end
      OP_PREF: aluop = ALU_SLL;
      default: inv = 1'b1;
    endcase
  end

  assign imm1 = ext_imm(e1, inst);
  assign imm2 = ext_imm(e2, inst);

endmodule

// File: rtl/id_pipe.sv
// Registered decode stage: operand bypass, load-use stall and
// valid/ready output register between IF/ID and EX.
module id_pipe
  import id_defs_pkg::*;
#(
  parameter int NUM_FWD = 2,
  parameter int ALUOP_W = 8,
  parameter int RADDR_W = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush_i,
  input  logic                   valid_i,
  output logic                   ready_o,
  input  logic [31:0]            pc_i,
  input  logic [31:0]            inst_i,
  output logic [RADDR_W-1:0]     reg1_addr_o,
  output logic                   reg1_read_o,
  input  logic [31:0]            reg1_data_i,
  output logic [RADDR_W-1:0]     reg2_addr_o,
  output logic                   reg2_read_o,
  input  logic [31:0]            reg2_data_i,
  input  logic [NUM_FWD-1:0]     fwd_wreg_i,
  input  logic [NUM_FWD*RADDR_W-1:0] fwd_wd_i,
  input  logic [NUM_FWD*32-1:0]  fwd_wdata_i,
  input  logic [NUM_FWD-1:0]     fwd_pend_i,
  output logic                   valid_o,
  input  logic                   ready_i,
  output logic [31:0]            pc_o,
  output logic [ALUOP_W-1:0]     aluop_o,
  output logic [31:0]            reg1_o,
  output logic [31:0]            reg2_o,
  output logic [RADDR_W-1:0]     wd_o,
  output logic                   wreg_o,
  output logic                   inv_inst_o
);

  logic [7:0]  d_aluop;
  logic        d_re1;
  logic        d_re2;
  logic [4:0]  d_wd;
  logic        d_wreg;
  logic [31:0] d_imm1;
  logic [31:0] d_imm2;
  logic        d_inv;

  id_decode u_dec (
    .inst  (inst_i),
    .aluop (d_aluop),
    .re1   (d_re1),
    .re2   (d_re2),
    .wd    (d_wd),
    .wreg  (d_wreg),
    .imm1  (d_imm1),
    .imm2  (d_imm2),
    .inv   (d_inv)
  );

  assign reg1_addr_o = RADDR_W'(inst_i[25:21]);
  assign reg2_addr_o = RADDR_W'(inst_i[20:16]);
  assign reg1_read_o = d_re1;
  assign reg2_read_o = d_re2;

  // {pend, data}: lowest-index matching source wins; $0 never bypassed
  function automatic logic [32:0] resolve(
    input logic [RADDR_W-1:0]     addr,
    input logic [31:0]            rf
  );
    logic [32:0] r;
    r = {1'b0, rf};
    for (int k = NUM_FWD - 1; k >= 0; k--) begin
      if (fwd_wreg_i[k] &&
          fwd_wd_i[k*RADDR_W +: RADDR_W] == addr)
        r = {fwd_pend_i[k], fwd_wdata_i[k*32 +: 32]};
    end
    if (addr == '0)
      r = 33'h0;
    return r;
  endfunction

  logic [32:0] r1;
  logic [32:0] r2;
  logic [31:0] op1;
  logic [31:0] op2;
  logic        hazard;
  logic        adv;

  assign r1  = resolve(reg1_addr_o, reg1_data_i);
  assign r2  = resolve(reg2_addr_o, reg2_data_i);
  assign op1 = d_re1 ? r1[31:0] : d_imm1;
  assign op2 = d_re2 ? r2[31:0] : d_imm2;

  assign hazard  = valid_i && ((d_re1 && r1[32]) ||
                               (d_re2 && r2[32]));
  assign adv     = !valid_o || ready_i;
  assign ready_o = adv && !hazard && !flush_i;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_o    <= 1'b0;
      pc_o       <= '0;
      aluop_o    <= '0;
      reg1_o     <= '0;
      reg2_o     <= '0;
      wd_o       <= '0;
      wreg_o     <= 1'b0;
      inv_inst_o <= 1'b0;
    end else if (flush_i) begin
      valid_o <= 1'b0;
    end else if (adv) begin
      if (hazard) begin
        valid_o <= 1'b0;
      end else if (valid_i) begin
        valid_o    <= 1'b1;
        pc_o       <= pc_i;
        aluop_o    <= ALUOP_W'(d_aluop);
        reg1_o     <= op1;
        reg2_o     <= op2;
        wd_o       <= RADDR_W'(d_wd);
        wreg_o     <= d_wreg;
        inv_inst_o <= d_inv;
      end else begin
        valid_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_id_pipe.sv
// Directed self-checking bench for id_pipe.
module tb_id_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush_i;
  logic        valid_i;
  logic        ready_o;
  logic [31:0] pc_i;
  logic [31:0] inst_i;
  logic [4:0]  reg1_addr_o;
  logic        reg1_read_o;
  logic [31:0] reg1_data_i;
  logic [4:0]  reg2_addr_o;
  logic        reg2_read_o;
  logic [31:0] reg2_data_i;
  logic [1:0]  fwd_wreg_i;
  logic [9:0]  fwd_wd_i;
  logic [63:0] fwd_wdata_i;
  logic [1:0]  fwd_pend_i;
  logic        valid_o;
  logic        ready_i;
  logic [31:0] pc_o;
  logic [7:0]  aluop_o;
  logic [31:0] reg1_o;
  logic [31:0] reg2_o;
  logic [4:0]  wd_o;
  logic        wreg_o;
  logic        inv_inst_o;

  int n_chk = 0;
  int n_fail = 0;

  logic [31:0] rf [32];

  always #5 clk = ~clk;

  assign reg1_data_i = rf[reg1_addr_o];
  assign reg2_data_i = rf[reg2_addr_o];

  id_pipe #(.NUM_FWD(2), .ALUOP_W(8), .RADDR_W(5)) dut (
    .clk(clk), .rst(rst), .flush_i(flush_i),
    .valid_i(valid_i), .ready_o(ready_o),
    .pc_i(pc_i), .inst_i(inst_i),
    .reg1_addr_o(reg1_addr_o), .reg1_read_o(reg1_read_o),
    .reg1_data_i(reg1_data_i),
    .reg2_addr_o(reg2_addr_o), .reg2_read_o(reg2_read_o),
    .reg2_data_i(reg2_data_i),
    .fwd_wreg_i(fwd_wreg_i), .fwd_wd_i(fwd_wd_i),
    .fwd_wdata_i(fwd_wdata_i), .fwd_pend_i(fwd_pend_i),
    .valid_o(valid_o), .ready_i(ready_i),
    .pc_o(pc_o), .aluop_o(aluop_o),
    .reg1_o(reg1_o), .reg2_o(reg2_o),
    .wd_o(wd_o), .wreg_o(wreg_o),
    .inv_inst_o(inv_inst_o)
  );

  // {valid, wreg, inv, aluop, wd, reg1, reg2}
  logic [79:0] obs;
  assign obs = {valid_o, wreg_o, inv_inst_o, aluop_o,
                wd_o, reg1_o, reg2_o};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    valid_i = 1'b0;
    ready_i = 1'b1;
    flush_i = 1'b0;
    fwd_wreg_i = '0;
    fwd_pend_i = '0;
    fwd_wd_i = '0;
    fwd_wdata_i = '0;
    step();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    flush_i = 1'b0;
    valid_i = 1'b0;
    ready_i = 1'b1;
    pc_i = '0;
    inst_i = '0;
    fwd_wreg_i = '0;
    fwd_pend_i = '0;
    fwd_wd_i = '0;
    fwd_wdata_i = '0;
    #2;
    n_chk++;
    if ({obs, pc_o} !== 112'h0) begin
      n_fail++;
      $display("FAIL reset got %h/%h want 0", obs, pc_o);
    end
    step();
    @(negedge clk);
    rst = 1'b1;
    step();
  endtask

  task automatic test_ori();
    pc_i = 32'h100;
    inst_i = 32'h34018001;
    valid_i = 1'b1;
    #1;
    n_chk++;
    if ({ready_o, reg1_read_o, reg2_read_o} !== 3'b110) begin
      n_fail++;
      $display("FAIL ori_ctl got %b%b%b want 110",
               ready_o, reg1_read_o, reg2_read_o);
    end
    step();
    valid_i = 1'b0;
    n_chk++;
    if (obs !== {3'b110, 8'h25, 5'd1, 32'h0, 32'h8001}) begin
      n_fail++;
      $display("FAIL ori got %h", obs);
    end
    n_chk++;
    if (pc_o !== 32'h100) begin
      n_fail++;
      $display("FAIL ori_pc got %h want 100", pc_o);
    end
  endtask

  task automatic test_addi();
    pc_i = 32'h104;
    inst_i = 32'h2062FFFF;
    valid_i = 1'b1;
    step();
    valid_i = 1'b0;
    n_chk++;
    if (obs !== {3'b110, 8'h20, 5'd2, 32'd5,
                 32'hFFFFFFFF}) begin
      n_fail++;
      $display("FAIL addi got %h", obs);
    end
  endtask

  task automatic test_fwd_priority();
    inst_i = 32'h00212025;
    fwd_wreg_i = 2'b11;
    fwd_wd_i = {5'd1, 5'd1};
    fwd_wdata_i = {32'hBB, 32'hAA};
    valid_i = 1'b1;
    step();
    valid_i = 1'b0;
    n_chk++;
    if (obs !== {3'b110, 8'h25, 5'd4, 32'hAA, 32'hAA}) begin
      n_fail++;
      $display("FAIL fwd_prio got %h", obs);
    end
    fwd_wreg_i = 2'b00;
  endtask

  task automatic test_load_use();
    inst_i = 32'h00C02824;
    fwd_wreg_i = 2'b01;
    fwd_wd_i = {5'd0, 5'd6};
    fwd_pend_i = 2'b01;
    fwd_wdata_i = '0;
    valid_i = 1'b1;
    #1;
    n_chk++;
    if (ready_o !== 1'b0) begin
      n_fail++;
      $display("FAIL lu_stall ready got %b want 0", ready_o);
    end
    step();
    n_chk++;
    if (valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL lu_bubble valid got %b want 0", valid_o);
    end
    fwd_pend_i = 2'b00;
    fwd_wdata_i = {32'h0, 32'h1234};
    #1;
    n_chk++;
    if (ready_o !== 1'b1) begin
      n_fail++;
      $display("FAIL lu_release ready got %b want 1", ready_o);
    end
    step();
    valid_i = 1'b0;
    n_chk++;
    if (obs !== {3'b110, 8'h24, 5'd5, 32'h1234, 32'h0}) begin
      n_fail++;
      $display("FAIL lu_issue got %h", obs);
    end
    fwd_wreg_i = 2'b00;
  endtask

  task automatic test_shadow();
    inst_i = 32'h00C02824;
    fwd_wreg_i = 2'b11;
    fwd_wd_i = {5'd6, 5'd6};
    fwd_pend_i = 2'b10;
    fwd_wdata_i = {32'hDEAD, 32'h77};
    valid_i = 1'b1;
    #1;
    n_chk++;
    if (ready_o !== 1'b1) begin
      n_fail++;
      $display("FAIL shadow ready got %b want 1", ready_o);
    end
    step();
    valid_i = 1'b0;
    n_chk++;
    if (obs !== {3'b110, 8'h24, 5'd5, 32'h77, 32'h0}) begin
      n_fail++;
      $display("FAIL shadow got %h", obs);
    end
    fwd_wreg_i = 2'b00;
    fwd_pend_i = 2'b00;
  endtask

  task automatic test_shift_lui();
    inst_i = 32'h00083900;
    valid_i = 1'b1;
    #1;
    n_chk++;
    if ({reg1_read_o, reg2_read_o} !== 2'b01) begin
      n_fail++;
      $display("FAIL sll_rd got %b%b want 01",
               reg1_read_o, reg2_read_o);
    end
    step();
    n_chk++;
    if (obs !== {3'b110, 8'h7C, 5'd7, 32'd4, 32'h108}) begin
      n_fail++;
      $display("FAIL sll got %h", obs);
    end
    inst_i = 32'h3C091234;
    step();
    valid_i = 1'b0;
    n_chk++;
    if (obs !== {3'b110, 8'h25, 5'd9, 32'h0,
                 32'h12340000}) begin
      n_fail++;
      $display("FAIL lui got %h", obs);
    end
  endtask

  task automatic test_back_to_back();
    logic [79:0] held;
    idle();
    pc_i = 32'h300;
    inst_i = 32'h34018001;
    valid_i = 1'b1;
    ready_i = 1'b0;
    step();
    held = {3'b110, 8'h25, 5'd1, 32'h0, 32'h8001};
    pc_i = 32'h304;
    inst_i = 32'h2062FFFF;
    for (int i = 0; i < 3; i++) begin
      n_chk++;
      if ({ready_o, obs, pc_o} !== {1'b0, held, 32'h300}) begin
        n_fail++;
        $display("FAIL stall%0d rdy %b got %h pc %h",
                 i, ready_o, obs, pc_o);
      end
      step();
    end
    ready_i = 1'b1;
    #1;
    n_chk++;
    if (ready_o !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_release ready got %b", ready_o);
    end
    step();
    valid_i = 1'b0;
    n_chk++;
    if ({obs, pc_o} !== {3'b110, 8'h20, 5'd2, 32'd5,
                         32'hFFFFFFFF, 32'h304}) begin
      n_fail++;
      $display("FAIL stall_next got %h pc %h", obs, pc_o);
    end
  endtask

  task automatic test_invalid_flush();
    idle();
    inst_i = 32'hFC000000;
    valid_i = 1'b1;
    #1;
    n_chk++;
    if ({reg1_read_o, reg2_read_o} !== 2'b00) begin
      n_fail++;
      $display("FAIL inv_rd got %b%b want 00",
               reg1_read_o, reg2_read_o);
    end
    step();
    n_chk++;
    if ({valid_o, wreg_o, inv_inst_o, aluop_o} !==
        {3'b101, 8'h00}) begin
      n_fail++;
      $display("FAIL inv got v%b w%b i%b a%h",
               valid_o, wreg_o, inv_inst_o, aluop_o);
    end
    flush_i = 1'b1;
    #1;
    n_chk++;
    if (ready_o !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_ready got %b want 0", ready_o);
    end
    step();
    n_chk++;
    if (valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL flush got valid %b want 0", valid_o);
    end
    flush_i = 1'b0;
    inst_i = 32'h34018001;
    step();
    ready_i = 1'b0;
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    valid_i = 1'b0;
    n_chk++;
    if (valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_stall got valid %b want 0", valid_o);
    end
  endtask

  task automatic test_async_reset();
    idle();
    inst_i = 32'h34018001;
    valid_i = 1'b1;
    ready_i = 1'b0;
    step();
    valid_i = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    n_chk++;
    if ({valid_o, reg2_o, wd_o} !== 38'h0) begin
      n_fail++;
      $display("FAIL async_rst got v%b r2 %h wd %h",
               valid_o, reg2_o, wd_o);
    end
    @(negedge clk);
    rst = 1'b1;
    ready_i = 1'b1;
    step();
  endtask

  initial begin
    for (int i = 0; i < 32; i++)
      rf[i] = 32'h100 + i;
    rf[0] = 32'h0;
    rf[3] = 32'd5;
    test_reset();
    test_ori();
    test_addi();
    test_fwd_priority();
    test_load_use();
    test_shadow();
    test_shift_lui();
    test_back_to_back();
    test_invalid_flush();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/id_pipe.md
Name: id_pipe

Overview:
- Parametrised successor of the combinational decode stage. Decodes one 32-bit MIPS instruction per cycle.
- Resolves operands through a configurable number of bypass sources.
- Detects load-use hazards and stalls upstream on them.
- Holds the decoded result in an output register with valid/ready handshakes on both sides. Sits between the IF/ID register and EX.

Parameters:
NUM_FWD, 2, number of bypass sources; index 0 = youngest (EX), highest priority
ALUOP_W, 8, width of aluop_o
RADDR_W, 5, register-number width

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low
flush_i  in  1  synchronous pipeline flush
valid_i  in  1  inst_i/pc_i valid
ready_o  out  1  stage accepts the input this cycle
pc_i  in  32  instruction address
inst_i  in  32  instruction word
reg1_addr_o  out  RADDR_W  regfile read port 1 address (combinational, inst_i[25:21])
reg1_read_o  out  1  read port 1 enable (combinational)
reg1_data_i  in  32  read port 1 data
reg2_addr_o  out  RADDR_W  regfile read port 2 address (combinational, inst_i[20:16])
reg2_read_o  out  1  read port 2 enable (combinational)
reg2_data_i  in  32  read port 2 data
fwd_wreg_i  in  NUM_FWD  source k writes a register
fwd_wd_i  in  NUM_FWD*RADDR_W  destination of source k, slice k
fwd_wdata_i  in  NUM_FWD*32  result of source k, slice k
fwd_pend_i  in  NUM_FWD  source k result not yet available (load)
valid_o  out  1  registered output valid
ready_i  in  1  EX accepts
pc_o  out  32  registered pc
aluop_o  out  ALUOP_W  registered ALU operation
reg1_o  out  32  registered operand 1
reg2_o  out  32  registered operand 2
wd_o  out  RADDR_W  registered destination
wreg_o  out  1  registered write enable
inv_inst_o  out  1  registered invalid-opcode flag

Behaviour:
- Reset (rst=0, async): valid_o=0; all other registered outputs = 0.
- Decode is combinational from inst_i. Selected aluop per instruction:
  - R-type (read rs, rt; wd=rd): and 0x24, or 0x25, xor 0x26, nor 0x27, add 0x20, addu 0x21, sub 0x22, subu 0x23, slt 0x2A, sltu 0x2B, sllv 0x7C, srlv 0x02, srav 0x03.
  - sll/srl/sra: read rt; operand1 = zero-extended shamt; same codes as the variable shifts.
  - sync: aluop 0x7C, wreg=0.
  - I-type (read rs; wd=rt; wreg=1):
    - andi/ori/xori: zero-extended imm16.
    - addi/addiu/slti/sltiu: sign-extended imm16; aluop 0x20/0x21/0x2A/0x2B.
    - lui: {imm16,16'h0}, aluop or 0x25, operand1 = 0, no rs read.
  - pref: aluop 0x7C, wreg=0, no reads.
  - Any other opcode or funct: aluop 0, wreg=0, no reads, inv_inst_o=1.
- Operand resolution per port (operand not read -> immediate, or 0 if none):
  - Address 0 -> 0; never forwarded.
  - Otherwise use the lowest k with fwd_wreg_i[k] && fwd_wd_i[k]==addr: fwd_wdata_i[k].
  - No match -> regfile data.
- Hazard:
  - hazard = valid_i && (a read port's winning match k has fwd_pend_i[k]=1).
  - Only the highest-priority match is checked; a pending older source shadowed by a younger non-pending match causes no stall.
- Handshake:
  - adv = !valid_o || ready_i.
  - ready_o = adv && !hazard && !flush_i.
- Clock edge, in priority order:
  - flush_i: valid_o <= 0; input dropped.
  - adv && hazard: valid_o <= 0 (bubble); outputs hold the instruction not yet taken.
  - adv && valid_i: load all outputs, valid_o <= 1.
  - adv && !valid_i: valid_o <= 0.
  - !adv: all outputs hold.
- Boundaries:
  - While valid_o=1 && ready_i=0, outputs are stable.
  - Flush during downstream stall still clears valid_o.
  - Mid-operation async reset clears valid_o immediately.

Decomposition:
- Package id_defs_pkg: opcode/funct constants, aluop constants, NOP aluop, imm-extension enum.
- Sub-module id_decode: combinational inst -> {aluop, reads, wd, wreg, imm, inv}.
- id_pipe holds the forwarding mux, hazard detection and output register.

Test Plan:
- ori $1,$0,0x8001, ready_i=1 -> next cycle valid_o=1, aluop 0x25, reg1_o=0, reg2_o=0x00008001, wd_o=1.
- addi $2,$3,-1 with $3=5 in regfile -> reg1_o=5, reg2_o=0xFFFFFFFF, aluop 0x20.
- or $4,$1,$1 with fwd0={wreg,wd=1,data=0xAA}, fwd1={wreg,wd=1,data=0xBB} -> reg1_o=reg2_o=0xAA.
- and $5,$6,$0 with fwd0={wd=6,pend=1} -> ready_o=0, bubble; pend dropped next cycle -> issues with forwarded value.
- ready_i=0 for 3 cycles with valid_o=1 -> outputs and ready_o=0 stable; ready_i=1 -> next instruction accepted.
- opcode 0x3F -> inv_inst_o=1, wreg_o=0; flush_i asserted -> valid_o=0 next cycle.
